// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, combinational imem addressing and IF/ID
// pipeline register with stall/flush/redirect handling and fetch bookkeeping.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_f,
   input  logic        stall_d,
   input  logic        flush_d,
   input  logic        pc_src_e,
   input  logic [31:0] pc_target_e,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rd,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus4_d,
   output logic        valid_d,
   output logic        misalign_err,
   output logic [31:0] fetch_count
);

   logic [31:0] r_pc;
   logic [31:0] r_instr_d;
   logic [31:0] r_pc_d;
   logic [31:0] r_pc_plus4_d;
   logic        r_valid_d;
   logic        r_misalign;
   logic [31:0] r_fetch_count;

   logic [31:0] w_pc_plus4;
   logic        w_load_d;

   assign w_pc_plus4 = r_pc + 32'd4;
   // A real instruction enters IF/ID only when neither flushed nor held.
   assign w_load_d   = !flush_d && !stall_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_instr_d     <= NOP_INSTR;
         r_pc_d        <= 32'd0;
         r_pc_plus4_d  <= 32'd0;
         r_valid_d     <= 1'b0;
         r_misalign    <= 1'b0;
         r_fetch_count <= 32'd0;
      end else begin
         // Redirect beats stall_f; the target is forced word aligned.
         if (pc_src_e)
            r_pc <= {pc_target_e[31:2], 2'b00};
         else if (!stall_f)
            r_pc <= w_pc_plus4;

         if (flush_d) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_valid_d    <= 1'b0;
         end else if (w_load_d) begin
            r_instr_d    <= imem_rd;
            r_pc_d       <= r_pc;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid_d    <= 1'b1;
         end

         if (w_load_d)
            r_fetch_count <= r_fetch_count + 32'd1;

         if (pc_src_e && (pc_target_e[1:0] != 2'b00))
            r_misalign <= 1'b1;
      end
   end

   assign imem_addr    = r_pc;
   assign pc_f         = r_pc;
   assign instr_d      = r_instr_d;
   assign pc_d         = r_pc_d;
   assign pc_plus4_d   = r_pc_plus4_d;
   assign valid_d      = r_valid_d;
   assign misalign_err = r_misalign;
   assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random control traffic, all
// checked against a cycle-level reference of the fetch rules kept here.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_f, stall_d, flush_d, pc_src_e;
   logic [31:0] pc_target_e;
   logic [31:0] imem_addr, imem_rd, pc_f, instr_d, pc_d, pc_plus4_d, fetch_count;
   logic        valid_d, misalign_err;

   // Second instance exercising address wrap from a high reset PC.
   logic        z_stall_f = 1'b0, z_stall_d = 1'b0, z_flush_d = 1'b0, z_pc_src_e = 1'b0;
   logic [31:0] z_target = 32'd0;
   logic [31:0] w_addr, w_rd, w_pc_f, w_instr_d, w_pc_d, w_pc4_d, w_cnt;
   logic        w_valid_d, w_mis;

   int checks   = 0;
   int failures = 0;

   // Reference state
   logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_cnt;
   logic        m_valid, m_mis;

   always #5 clk = ~clk;

   // Memory image: word equals its own byte address.
   assign imem_rd = imem_addr;
   assign w_rd    = w_addr;

   fetch_stage dut (
      .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
      .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(imem_addr),
      .imem_rd(imem_rd), .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d),
      .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .misalign_err(misalign_err),
      .fetch_count(fetch_count));

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(rst), .stall_f(z_stall_f), .stall_d(z_stall_d), .flush_d(z_flush_d),
      .pc_src_e(z_pc_src_e), .pc_target_e(z_target), .imem_addr(w_addr),
      .imem_rd(w_rd), .pc_f(w_pc_f), .instr_d(w_instr_d), .pc_d(w_pc_d),
      .pc_plus4_d(w_pc4_d), .valid_d(w_valid_d), .misalign_err(w_mis),
      .fetch_count(w_cnt));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("pc_f", pc_f, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("instr_d", instr_d, m_instr);
      chk("pc_d", pc_d, m_pcd);
      chk("pc_plus4_d", pc_plus4_d, m_pc4d);
      chk("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
      chk("fetch_count", fetch_count, m_cnt);
   endtask

   // Apply one clock with the currently driven inputs, advance the reference
   // from the fetch rules, then compare everything.
   task automatic step();
      logic [31:0] word;
      word = m_pc;  // memory image: word == address
      @(posedge clk);
      if (rst) begin
         m_pc = 32'h0; m_instr = 32'h13; m_pcd = 0; m_pc4d = 0;
         m_valid = 0; m_mis = 0; m_cnt = 0;
      end else begin
         if (pc_src_e && pc_target_e[1:0] != 0) m_mis = 1;
         if (flush_d) begin
            m_instr = 32'h13; m_pcd = 0; m_pc4d = 0; m_valid = 0;
         end else if (!stall_d) begin
            m_instr = word; m_pcd = m_pc; m_pc4d = m_pc + 4; m_valid = 1;
            m_cnt = m_cnt + 1;
         end
         if (pc_src_e)      m_pc = pc_target_e & 32'hFFFF_FFFC;
         else if (!stall_f) m_pc = m_pc + 4;
      end
      #1;
      chk_all();
   endtask

   task automatic idle();
      stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
   endtask

   initial begin
      rst = 1; idle();
      m_pc = 'x; m_instr = 'x; m_pcd = 'x; m_pc4d = 'x; m_valid = 'x; m_mis = 'x; m_cnt = 'x;
      step(); step();
      // Reset values as absolute constants
      chk("rst pc_f", pc_f, 32'h0);
      chk("rst instr_d", instr_d, 32'h0000_0013);
      chk("rst valid_d", {31'd0, valid_d}, 32'd0);
      chk("rst fetch_count", fetch_count, 32'd0);
      chk("wrap rst pc_f", w_pc_f, 32'hFFFF_FFFC);

      // Free run
      rst = 0;
      step();
      chk("run1 instr_d", instr_d, 32'h0);
      chk("run1 pc_plus4_d", pc_plus4_d, 32'h4);
      chk("run1 fetch_count", fetch_count, 32'd1);
      chk("wrap pc_f", w_pc_f, 32'h0);
      chk("wrap instr_d", w_instr_d, 32'hFFFF_FFFC);
      chk("wrap pc_plus4_d", w_pc4_d, 32'h0);
      step();
      chk("run2 instr_d", instr_d, 32'h4);
      chk("run2 pc_f", pc_f, 32'h8);

      // Stall two cycles at pc_f=0x8
      stall_f = 1; stall_d = 1;
      step(); step();
      chk("stall pc_f", pc_f, 32'h8);
      chk("stall instr_d", instr_d, 32'h4);
      chk("stall fetch_count", fetch_count, 32'd2);
      idle();
      step();
      chk("post-stall instr_d", instr_d, 32'h8);
      chk("post-stall fetch_count", fetch_count, 32'd3);

      // Redirect with flush, stall_f overridden
      pc_src_e = 1; pc_target_e = 32'h40; flush_d = 1; stall_f = 1;
      step();
      chk("redir pc_f", pc_f, 32'h40);
      chk("redir valid_d", {31'd0, valid_d}, 32'd0);
      chk("redir instr_d", instr_d, 32'h0000_0013);
      idle();
      step();
      chk("redir target instr_d", instr_d, 32'h40);

      // Misaligned redirect: sticky error, aligned PC
      pc_src_e = 1; pc_target_e = 32'h42;
      step();
      chk("mis pc_f", pc_f, 32'h40);
      chk("mis err", {31'd0, misalign_err}, 32'd1);
      idle();
      step(); step();
      chk("mis sticky", {31'd0, misalign_err}, 32'd1);

      // Flush beats stall_d
      flush_d = 1; stall_d = 1;
      step();
      chk("flush>stall valid_d", {31'd0, valid_d}, 32'd0);
      idle();
      step();

      // Random control traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         rst         = ($urandom_range(0, 39) == 0);
         stall_f     = ($urandom_range(0, 3) == 0);
         stall_d     = ($urandom_range(0, 3) == 0);
         flush_d     = ($urandom_range(0, 5) == 0);
         pc_src_e    = ($urandom_range(0, 7) == 0);
         pc_target_e = $urandom;
         if ($urandom_range(0, 2) != 0) pc_target_e[1:0] = 2'b00;
         step();
      end

      rst = 1; idle();
      step();
      chk("final rst misalign", {31'd0, misalign_err}, 32'd0);
      chk("final rst count", fetch_count, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
